divider_seq: RTL and testbench
==============================

// Module: divider_seq
// PURPOSE
//  Multi-cycle signed 32-bit integer divider; completes the arithmetic path from the opposite direction to
//  the adder: repeated trial subtraction through a cla instance. Sits beside the ALU in the execute stage
//  and is driven by the pipeline stall logic via a start/ready handshake. Quotient only, truncated toward 0.
// PARAMETERS
//  WIDTH   32  operand/result width; only 32 supported (cla is fixed 32-bit)
//  SIGNED  1   1: two's-complement operands/result; 0: unsigned, sign fix-up bypassed
// PORTS
//  clock           in   1   single clock, all state changes on rising edge
//  reset           in   1   synchronous, active-high; wins over every other input
//  ctrl_DIV        in   1   start pulse; operands sampled on the same edge
//  data_operandA   in   32  dividend
//  data_operandB   in   32  divisor
//  data_result     out  32  quotient; held stable until next start or reset
//  data_exception  out  1   divide-by-zero flag, valid while data_resultRDY=1
//  data_resultRDY  out  1   one-cycle completion pulse
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, iter count=0.
//  - States: IDLE -> RUN (ctrl_DIV, B!=0); IDLE -> DONE (ctrl_DIV, B==0); RUN -> DONE after 32nd iteration;
//    DONE -> IDLE next edge. ctrl_DIV in any state restarts: relatch operands, count=0; pending result dropped.
//  - Start edge N: latch |A|, |B| (abs via ~x+1 through cla when SIGNED and sign bit set), neg_q = A[31]^B[31],
//    zero-check B. Remainder reg cleared, quotient reg = |A|.
//  - RUN: one restoring step per edge: {R,Q} shifted left 1; T = R - |B| via cla(R, ~|B|, Cin=1);
//    Cout=1 (no borrow) -> R=T, Q[0]=1; else R kept, Q[0]=0. 6-bit counter, 32 steps, edges N+1..N+32.
//  - DONE entered on edge N+32; on edge N+33 data_result = neg_q ? -Q : Q, data_resultRDY=1 for exactly
//    that cycle (deasserts at N+34). Total latency: RDY visible 33 edges after start.
//  - Divide by zero: no iterations; edge N+1 sets data_result=0, data_exception=1, data_resultRDY=1 (1 cycle).
//  - data_exception cleared on next start; otherwise held with data_result.
//  - Overflow 0x80000000 / 0xFFFFFFFF: result wraps to 0x80000000, data_exception=0.
//  - |0x80000000| stays 0x80000000, handled correctly as unsigned magnitude in datapath.
//  - Dividend magnitude < divisor -> quotient 0 (sign of zero irrelevant, result 0x00000000).
//  - Reset mid-RUN: abort, no RDY pulse ever issued for aborted op. Reset and ctrl_DIV same edge: start ignored.
//  - ctrl_DIV held high continuously: restarts every edge, never completes (caller must pulse).
//  - Operand inputs ignored except on start edge.
// STRUCTURE
//  - Shared header (divider_defs.vh): state encodings IDLE/RUN/DONE, DIV_ITERS=32, WIDTH=32.
//  - Sub-module: existing cla (32-bit) reused; one instance for trial subtraction, one shared for
//    abs-on-entry and negate-on-exit (muxed inputs; the two uses never coincide in the same cycle).
//  - Registers: state, count[5:0], R[31:0], Q[31:0], divisor mag[31:0], neg_q, outputs.
// TESTING
//  1. 100 / 7 -> data_result=14 (0x0000000E), exc=0, RDY single pulse exactly 33 edges after start.
//  2. -100/7, 100/-7 -> 0xFFFFFFF2; -100/-7 -> 14; 7/100 -> 0; 0x80000000/1 -> 0x80000000.
//  3. 5 / 0 -> RDY one edge after start, data_result=0, exc=1; next 6/3 -> 2, exc=0.
//  4. 0x80000000 / 0xFFFFFFFF -> 0x80000000, exc=0; 0xFFFFFFFF/0xFFFFFFFF -> 1.
//  5. Start 100/7, restart at edge 10 with 9/3 -> only one RDY, 33 edges after 2nd start, result 3.
//  6. Reset at edge 20 of RUN -> no RDY, outputs 0; reset+ctrl_DIV same edge -> stays IDLE.

Source files
------------

// File: rtl/divider_seq_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
// Only the 32-bit configuration is supported, because the CLA is a fixed 32-bit adder.
package divider_seq_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/divider_seq_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, with the group carry chained between groups.
// Purely combinational.
module divider_seq_cla
    import divider_seq_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] i_a,
    input  logic [DIV_WIDTH-1:0] i_b,
    input  logic                 i_cin,
    output logic [DIV_WIDTH-1:0] o_sum,
    output logic                 o_cout
);
    localparam int NGRP = DIV_WIDTH / 4;

    logic [DIV_WIDTH-1:0] w_g;
    logic [DIV_WIDTH-1:0] w_p;
    logic [DIV_WIDTH-1:0] w_c;
    logic [NGRP:0]        w_gc;

    assign w_g     = i_a & i_b;
    assign w_p     = i_a ^ i_b;
    assign w_gc[0] = i_cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic [3:0] w_g4;
        logic [3:0] w_p4;
        logic       w_ci;
        assign w_g4 = w_g[4*k +: 4];
        assign w_p4 = w_p[4*k +: 4];
        assign w_ci = w_gc[k];

        assign w_c[4*k]   = w_ci;
        assign w_c[4*k+1] = w_g4[0] | (w_p4[0] & w_ci);
        assign w_c[4*k+2] = w_g4[1] | (w_p4[1] & w_g4[0]) | (w_p4[1] & w_p4[0] & w_ci);
        assign w_c[4*k+3] = w_g4[2] | (w_p4[2] & w_g4[1]) | (w_p4[2] & w_p4[1] & w_g4[0])
                          | (w_p4[2] & w_p4[1] & w_p4[0] & w_ci);
        assign w_gc[k+1]  = w_g4[3] | (w_p4[3] & w_g4[2]) | (w_p4[3] & w_p4[2] & w_g4[1])
                          | (w_p4[3] & w_p4[2] & w_p4[1] & w_g4[0]) | ((&w_p4) & w_ci);
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[NGRP];
endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider: quotient truncated toward zero, 33 edges from start to the RDY pulse.
// A divide by zero finishes on the next edge with the exception flag set; ctrl_DIV restarts the divider from any state.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dmag;
    logic             r_neg;
    logic             r_dz;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;

    logic [WIDTH-1:0] w_neg_in;
    logic [WIDTH-1:0] w_neg_out;
    logic             w_unused_neg_cout;
    logic [WIDTH-1:0] w_r_sh;
    logic [WIDTH-1:0] w_trial_a;
    logic [WIDTH-1:0] w_trial_b;
    logic [WIDTH-1:0] w_trial_sum;
    logic             w_trial_cout;
    logic             w_take;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_out;
    logic             w_b_zero;

    // Shared negator: takes |A| on a start edge and the signed quotient in DONE.
    // A start always overrides DONE, so the two uses never compete.
    assign w_neg_in = ctrl_DIV ? data_operandA : r_quo;

    divider_seq_cla u_neg (
        .i_a   (~w_neg_in),
        .i_b   ('0),
        .i_cin (1'b1),
        .o_sum (w_neg_out),
        .o_cout(w_unused_neg_cout)
    );

    // On a start edge the trial subtractor is otherwise idle, so it computes 0 - B for |B|.
    assign w_r_sh    = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_trial_a = ctrl_DIV ? '0 : w_r_sh;
    assign w_trial_b = ~(ctrl_DIV ? data_operandB : r_dmag);

    divider_seq_cla u_trial (
        .i_a   (w_trial_a),
        .i_b   (w_trial_b),
        .i_cin (1'b1),
        .o_sum (w_trial_sum),
        .o_cout(w_trial_cout)
    );

    // A bit shifted out of the remainder means the shifted value is at least 2^32, which always exceeds the divisor.
    assign w_take   = w_trial_cout | r_rem[WIDTH-1];
    assign w_a_mag  = (SIGNED && data_operandA[WIDTH-1]) ? w_neg_out   : data_operandA;
    assign w_b_mag  = (SIGNED && data_operandB[WIDTH-1]) ? w_trial_sum : data_operandB;
    assign w_q_out  = r_neg ? w_neg_out : r_quo;
    assign w_b_zero = (data_operandB == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dmag   <= '0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_DIV) begin
                r_rem   <= '0;
                r_quo   <= w_a_mag;
                r_dmag  <= w_b_mag;
                r_neg   <= SIGNED && (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
                r_dz    <= w_b_zero;
                r_exc   <= 1'b0;
                r_count <= '0;
                r_state <= w_b_zero ? ST_DONE : ST_RUN;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_rem   <= w_take ? w_trial_sum : w_r_sh;
                        r_quo   <= {r_quo[WIDTH-2:0], w_take};
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(DIV_ITERS - 1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_result <= r_dz ? '0 : w_q_out;
                        r_exc    <= r_dz;
                        r_rdy    <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: a latency and arithmetic reference model checked on every cycle, plus directed literal cases.
module tb_divider_seq;
    logic        clk;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    divider_seq #(.WIDTH(32), .SIGNED(1'b1)) dut (
        .clock         (clk),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (opA),
        .data_operandB (opB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        if (b == 32'd0) return 32'd0;
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        return q[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: fixed latency (33 edges, or 1 for B==0) and plain signed division.
    logic        m_busy;
    int          m_left;
    logic [31:0] m_pres;
    logic        m_pexc;
    logic [31:0] m_result;
    logic        m_exc;
    logic        m_rdy;

    always @(posedge clk) begin
        m_rdy <= 1'b0;
        if (reset) begin
            m_busy   <= 1'b0;
            m_result <= 32'd0;
            m_exc    <= 1'b0;
        end else if (ctrl_DIV) begin
            m_busy <= 1'b1;
            m_left <= (opB == 32'd0) ? 1 : 33;
            m_pres <= ref_q(opA, opB);
            m_pexc <= (opB == 32'd0);
            m_exc  <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_rdy    <= 1'b1;
                m_result <= m_pres;
                m_exc    <= m_pexc;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rdy", {31'd0, data_resultRDY}, {31'd0, m_rdy});
            chk("cyc_result", data_result, m_result);
            chk("cyc_exc", {31'd0, data_exception}, {31'd0, m_exc});
        end
    end

    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        opA      = a;
        opB      = b;
        ctrl_DIV = 1'b1;
        @(negedge clk);
        ctrl_DIV = 1'b0;
        opA      = $urandom;
        opB      = $urandom;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (data_resultRDY !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        int lat;
        do_start(a, b);
        wait_rdy(lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_res"}, data_result, exp_res);
        chk({name, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(negedge clk);
        chk({name, "_pulse"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    task automatic count_rdy(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] la;
        logic [31:0] lb;

        reset    = 1'b1;
        ctrl_DIV = 1'b0;
        opA      = 32'd0;
        opB      = 32'd0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_result", data_result, 32'd0);
        chk("rst_exc", {31'd0, data_exception}, 32'd0);
        chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("p100_7",  32'd100,            32'd7,            32'h0000000E, 1'b0, 33);
        run_op("n100_7",  -32'sd100,          32'd7,            32'hFFFFFFF2, 1'b0, 33);
        run_op("p100_n7", 32'd100,            -32'sd7,          32'hFFFFFFF2, 1'b0, 33);
        run_op("n100_n7", -32'sd100,          -32'sd7,          32'h0000000E, 1'b0, 33);
        run_op("p7_100",  32'd7,              32'd100,          32'h00000000, 1'b0, 33);
        run_op("min_1",   32'h80000000,       32'd1,            32'h80000000, 1'b0, 33);
        run_op("div0",    32'd5,              32'd0,            32'h00000000, 1'b1, 1);
        run_op("p6_3",    32'd6,              32'd3,            32'h00000002, 1'b0, 33);
        run_op("ovf",     32'h80000000,       32'hFFFFFFFF,     32'h80000000, 1'b0, 33);
        run_op("m1_m1",   32'hFFFFFFFF,       32'hFFFFFFFF,     32'h00000001, 1'b0, 33);

        // Restart at edge 10 of a running op: only the second one completes.
        do_start(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        do_start(32'd9, 32'd3);
        wait_rdy(lat);
        chk("restart_lat", lat, 33);
        chk("restart_res", data_result, 32'd3);
        count_rdy(40, cnt);
        chk("restart_single", cnt, 0);

        // Reset at edge 20 of a run aborts with no pulse.
        do_start(32'd100, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_rdy(40, cnt);
        chk("abort_rdy", cnt, 0);
        chk("abort_res", data_result, 32'd0);
        chk("abort_exc", {31'd0, data_exception}, 32'd0);

        // Reset and start on the same edge: the start is ignored.
        opA = 32'd50; opB = 32'd5; ctrl_DIV = 1'b1; reset = 1'b1;
        @(negedge clk);
        ctrl_DIV = 1'b0; reset = 1'b0;
        count_rdy(40, cnt);
        chk("rst_start_rdy", cnt, 0);

        // ctrl_DIV held high never completes; the last sampled operands finish after release.
        ctrl_DIV = 1'b1;
        cnt = 0;
        la = 32'd0;
        lb = 32'd1;
        repeat (50) begin
            la  = $urandom;
            lb  = $urandom_range(1, 1000);
            opA = la;
            opB = lb;
            @(negedge clk);
            if (data_resultRDY === 1'b1) cnt++;
        end
        ctrl_DIV = 1'b0;
        chk("hold_rdy", cnt, 0);
        wait_rdy(lat);
        chk("hold_lat", lat, 33);
        chk("hold_res", data_result, ref_q(la, lb));

        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = $urandom_range(1, 16);
                2: b = -$urandom_range(1, 16);
                3: a = 32'h80000000;
                4: b = 32'hFFFFFFFF;
                5: a = $urandom_range(0, 20);
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                do_start($urandom, $urandom_range(1, 99));
                repeat ($urandom_range(0, 30)) @(negedge clk);
            end
            do_start(a, b);
            wait_rdy(lat);
            chk("rnd_lat", lat, (b == 32'd0) ? 1 : 33);
            chk("rnd_res", data_result, ref_q(a, b));
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
